// File: rtl/paula_audio_mixer_seq.sv
// Time-multiplexed Paula stereo mixer: one shared multiplier scales each channel by its
// volume, pan mask routes it left/right, frame result is saturated with optional mono fold.
//
// state  | meaning
// S_LOAD | snapshot inputs, clear accumulators, idx = 0
// S_MAC  | multiply-accumulate channel idx into left or right
// S_OUT  | saturate and register outputs, pulse sum_valid
module paula_audio_mixer_seq #(
    parameter int                      CHANNELS  = 4,
    parameter int                      SAMPLE_W  = 8,
    parameter int                      VOL_W     = 7,
    parameter int                      OUT_W     = 16,
    parameter logic [CHANNELS-1:0]     LEFT_MASK = 4'b0110
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clk7_en,
    input  logic [CHANNELS*SAMPLE_W-1:0] sample,
    input  logic [CHANNELS*VOL_W-1:0]    vol,
    input  logic                         mono,
    output logic [OUT_W-1:0]             ldatasum,
    output logic [OUT_W-1:0]             rdatasum,
    output logic                         sum_valid
);
    localparam int PW    = SAMPLE_W + VOL_W;
    localparam int PW1   = PW + 1;
    localparam int ACC_W = PW + $clog2(CHANNELS) + 1;
    localparam int AW1   = ACC_W + 1;
    localparam int SW    = (OUT_W > AW1) ? OUT_W : AW1;
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(CHANNELS - 1);
    localparam logic [VOL_W-1:0]     VOL_MAX  = {1'b1, {(VOL_W-1){1'b0}}};
    localparam logic signed [SW-1:0] SAT_MAX  = SW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] SAT_MIN  = SW'(-(64'sd1 <<< (OUT_W - 1)));

    logic [1:0]                   state;
    logic [IDX_W-1:0]             idx;
    logic [CHANNELS*SAMPLE_W-1:0] snap_sample;
    logic [CHANNELS*VOL_W-1:0]    snap_vol;
    logic                         snap_mono;
    logic signed [ACC_W-1:0]      acc_l;
    logic signed [ACC_W-1:0]      acc_r;

    logic [SAMPLE_W-1:0]          cur_sample;
    logic [VOL_W-1:0]             cur_vol;
    logic [VOL_W-1:0]             veff;
    logic signed [PW:0]           mul_a;
    logic signed [PW:0]           mul_b;
    logic signed [PW:0]           prod_full;
    logic signed [PW-1:0]         prod;
    logic signed [ACC_W-1:0]      prod_ext;
    logic signed [AW1-1:0]        mono_sum;
    logic signed [AW1-1:0]        mono_half;

    function automatic logic [OUT_W-1:0] sat(input logic signed [SW-1:0] x);
        if (x > SAT_MAX)
            return SAT_MAX[OUT_W-1:0];
        else if (x < SAT_MIN)
            return SAT_MIN[OUT_W-1:0];
        else
            return x[OUT_W-1:0];
    endfunction

    always_comb begin
        cur_sample = snap_sample[idx*SAMPLE_W +: SAMPLE_W];
        cur_vol    = snap_vol[idx*VOL_W +: VOL_W];
        veff       = cur_vol[VOL_W-1] ? VOL_MAX : {1'b0, cur_vol[VOL_W-2:0]};
        // Volume is unsigned; zero-extend it before the signed multiply.
        mul_a      = PW1'($signed(cur_sample));
        mul_b      = PW1'($signed({1'b0, veff}));
        prod_full  = mul_a * mul_b;
        prod       = prod_full[PW-1:0];
        prod_ext   = ACC_W'(prod);
        mono_sum   = AW1'(acc_l) + AW1'(acc_r);
        mono_half  = mono_sum >>> 1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_LOAD;
            idx         <= '0;
            snap_sample <= '0;
            snap_vol    <= '0;
            snap_mono   <= 1'b0;
            acc_l       <= '0;
            acc_r       <= '0;
            ldatasum    <= '0;
            rdatasum    <= '0;
            sum_valid   <= 1'b0;
        end else begin
            // The valid pulse lasts one clk even when clk7_en is low on the next edge.
            sum_valid <= 1'b0;
            if (clk7_en) begin
                case (state)
                    S_LOAD: begin
                        snap_sample <= sample;
                        snap_vol    <= vol;
                        snap_mono   <= mono;
                        acc_l       <= '0;
                        acc_r       <= '0;
                        idx         <= '0;
                        state       <= S_MAC;
                    end
                    S_MAC: begin
                        if (LEFT_MASK[idx])
                            acc_l <= acc_l + prod_ext;
                        else
                            acc_r <= acc_r + prod_ext;
                        if (idx == IDX_LAST)
                            state <= S_OUT;
                        else
                            idx <= idx + IDX_W'(1);
                    end
                    S_OUT: begin
                        if (snap_mono) begin
                            ldatasum <= sat(SW'(mono_half));
                            rdatasum <= sat(SW'(mono_half));
                        end else begin
                            ldatasum <= sat(SW'(acc_l));
                            rdatasum <= sat(SW'(acc_r));
                        end
                        sum_valid <= 1'b1;
                        state     <= S_LOAD;
                    end
                    default: state <= S_LOAD;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_paula_audio_mixer_seq.sv
// Directed bench for paula_audio_mixer_seq: default instance plus an OUT_W=14 instance
// sharing the same stimulus, checked with immediate assertions.
module tb_paula_audio_mixer_seq;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk7_en;
    logic [31:0] sample;
    logic [27:0] vol;
    logic        mono;
    logic [15:0] ldatasum, rdatasum;
    logic        sum_valid;
    logic [13:0] ld14, rd14;
    logic        sv14;

    int checks = 0;
    int errors = 0;
    int n;
    bit gate = 1'b0;

    localparam logic [31:0] SAMP_A = {8'h80, 8'h7F, 8'h7F, 8'h80};
    localparam logic [27:0] VOL_A  = {7'h3F, 7'h7F, 7'h40, 7'h20};
    localparam logic [31:0] SAMP_B = {8'h80, 8'h7F, 8'h81, 8'h80};
    localparam logic [27:0] VOL_B  = {7'h00, 7'h00, 7'h01, 7'h00};

    paula_audio_mixer_seq dut (
        .clk(clk), .reset_n(reset_n), .clk7_en(clk7_en), .sample(sample), .vol(vol),
        .mono(mono), .ldatasum(ldatasum), .rdatasum(rdatasum), .sum_valid(sum_valid)
    );

    paula_audio_mixer_seq #(.OUT_W(14)) dut14 (
        .clk(clk), .reset_n(reset_n), .clk7_en(clk7_en), .sample(sample), .vol(vol),
        .mono(mono), .ldatasum(ld14), .rdatasum(rd14), .sum_valid(sv14)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Counts falling edges until sum_valid is seen (bounded); optionally toggles clk7_en.
    task automatic wait_valid(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (gate) clk7_en = ~clk7_en;
        end while (!sum_valid && cnt < 100);
    endtask

    initial begin
        reset_n = 1'b0;
        clk7_en = 1'b1;
        mono    = 1'b0;
        sample  = SAMP_A;
        vol     = VOL_A;
        repeat (2) @(negedge clk);
        check("reset_l", int'($signed(ldatasum)), 0);
        check("reset_r", int'($signed(rdatasum)), 0);
        check("reset_valid", int'(sum_valid), 0);
        check("reset_l14", int'($signed(ld14)), 0);

        reset_n = 1'b1;
        wait_valid(n);
        check("first_latency", n, 6);
        check("stereo_l", int'($signed(ldatasum)), 16256);
        check("stereo_r", int'($signed(rdatasum)), -12160);
        check("sat_l14", int'($signed(ld14)), 8191);
        check("sat_r14", int'($signed(rd14)), -8192);
        check("valid14", int'(sv14), 1);
        wait_valid(n);
        check("period", n, 6);
        check("stereo_l_repeat", int'($signed(ldatasum)), 16256);

        mono = 1'b1;
        wait_valid(n);
        check("mono_period", n, 6);
        check("mono_l", int'($signed(ldatasum)), 2048);
        check("mono_r", int'($signed(rdatasum)), 2048);

        sample = SAMP_B;
        vol    = VOL_B;
        wait_valid(n);
        check("mono_floor_l", int'($signed(ldatasum)), -64);
        check("mono_floor_r", int'($signed(rdatasum)), -64);
        check("mono_floor_l14", int'($signed(ld14)), -64);

        mono   = 1'b0;
        sample = SAMP_A;
        vol    = VOL_A;
        wait_valid(n);
        check("restore_l", int'($signed(ldatasum)), 16256);

        gate    = 1'b1;
        clk7_en = 1'b0;
        wait_valid(n);
        check("gated_period_a", n, 12);
        check("gated_l", int'($signed(ldatasum)), 16256);
        check("gated_r", int'($signed(rdatasum)), -12160);
        wait_valid(n);
        check("gated_period_b", n, 12);
        check("gated_l14", int'($signed(ld14)), 8191);
        gate    = 1'b0;
        clk7_en = 1'b1;
        wait_valid(n);
        check("ungated_r", int'($signed(rdatasum)), -12160);

        // Next posedge snapshots; change sample1 while the frame is in S_MAC.
        repeat (2) @(negedge clk);
        sample[15:8] = 8'h00;
        check("hold_l", int'($signed(ldatasum)), 16256);
        check("hold_valid", int'(sum_valid), 0);
        wait_valid(n);
        check("snap_latency", n, 4);
        check("snap_cur_l", int'($signed(ldatasum)), 16256);
        wait_valid(n);
        check("snap_next_l", int'($signed(ldatasum)), 8128);
        check("snap_next_r", int'($signed(rdatasum)), -12160);

        sample = SAMP_A;
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("midreset_l", int'($signed(ldatasum)), 0);
        check("midreset_r", int'($signed(rdatasum)), 0);
        check("midreset_valid", int'(sum_valid), 0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_valid(n);
        check("post_reset_latency", n, 6);
        check("post_reset_l", int'($signed(ldatasum)), 16256);
        check("post_reset_r", int'($signed(rdatasum)), -12160);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
